// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared completion-stage types and the ROB tag squash-range rule
//
// Purpose: default widths, slot/packet typedefs for the common data bus, and the
//          wrap-aware squash test shared by the ROB, RS and the CDB arbiter.
// Contents:
//    CDB_SLOT        held/tag/value holding register for one FU slot
//    CDB_PACKET      valid/tag/value broadcast on the common data bus
//    FU_DONE_PACKET  one-hot done vector, slot 1..NUM_FU
//    in_squash_range true when tag t lies in the mispredict window (B, T]
package cdb_arbiter_pkg;

   localparam int NUM_FU_DEF    = 6;
   localparam int XLEN_DEF      = 32;
   localparam int ROB_TAG_W_DEF = 5;

   typedef struct packed {
      logic                     held;
      logic [ROB_TAG_W_DEF-1:0] tag;
      logic [XLEN_DEF-1:0]      value;
   } CDB_SLOT;

   typedef struct packed {
      logic                     valid;
      logic [ROB_TAG_W_DEF-1:0] tag;
      logic [XLEN_DEF-1:0]      value;
   } CDB_PACKET;

   typedef logic [NUM_FU_DEF:1] FU_DONE_PACKET;

   // Tags are passed zero-extended so the rule works for any tag width.
   // Tag 0 means "no tag" and is never younger than a branch.
   function automatic logic in_squash_range(input logic [31:0] t,
                                            input logic [31:0] b,
                                            input logic [31:0] tail);
      if (t == 32'd0) return 1'b0;
      if (b <= tail) return (t > b) && (t <= tail);
      return (t > b) || (t <= tail);
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rtl/cdb_arbiter_rr_arbiter.sv - rotating-priority one-hot arbiter over slots 1..N
//
// Purpose: pick one requester, searching from last+1 and wrapping N -> 1.
// Ports:
//    req    in   [N:1]     request per slot
//    last   in   [IW-1:0]  index (1..N) of the previous grant
//    grant  out  [N:1]     one-hot grant, zero when no request
module rr_arbiter #(
   parameter int N  = 6,
   parameter int IW = $clog2(N + 1)
) (
   input  logic [N:1]    req,
   input  logic [IW-1:0] last,
   output logic [N:1]    grant
);

   int   idx;
   logic found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= N; k++) begin
         idx = ((int'(last) + k - 1) % N) + 1;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - buffers one FU result per slot and broadcasts round-robin on the CDB
//
// Purpose: completion stage; one {rob_tag, value} per cycle to RS/ROB/map table,
//          with a matching fu_done pulse; mispredicts drop younger buffered results.
// Ports:
//    clock, reset                     clock, asynchronous active-low reset
//    fu_result_valid/tag/value  in    per-slot result offer (slots 1..NUM_FU)
//    fu_result_ready            out   slot can take a result this cycle
//    branch_mispredict, branch_rob_tag, rob_tail_tag  in  squash window
//    cdb_valid/cdb_rob_tag/cdb_value  out  registered broadcast, zero when idle
//    fu_done                    out   one-hot slot whose result is on the CDB
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_FU    = 6,
   parameter int XLEN      = 32,
   parameter int ROB_TAG_W = 5
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic [NUM_FU:1]                    fu_result_valid,
   input  logic [NUM_FU:1][ROB_TAG_W-1:0]     fu_result_tag,
   input  logic [NUM_FU:1][XLEN-1:0]          fu_result_value,
   output logic [NUM_FU:1]                    fu_result_ready,
   input  logic                               branch_mispredict,
   input  logic [ROB_TAG_W-1:0]               branch_rob_tag,
   input  logic [ROB_TAG_W-1:0]               rob_tail_tag,
   output logic                               cdb_valid,
   output logic [ROB_TAG_W-1:0]               cdb_rob_tag,
   output logic [XLEN-1:0]                    cdb_value,
   output logic [NUM_FU:1]                    fu_done
);

   localparam int IW = $clog2(NUM_FU + 1);

   logic [NUM_FU:1]                held_q, held_d;
   logic [NUM_FU:1][ROB_TAG_W-1:0] tag_q, tag_d;
   logic [NUM_FU:1][XLEN-1:0]      value_q, value_d;
   logic [IW-1:0]                  last_q, last_d;

   logic                           cdb_valid_q, cdb_valid_d;
   logic [ROB_TAG_W-1:0]           cdb_tag_q, cdb_tag_d;
   logic [XLEN-1:0]                cdb_value_q, cdb_value_d;
   logic [NUM_FU:1]                fu_done_q;

   logic [NUM_FU:1] sq_held, sq_in, req, grant, ready, xfer;

   always_comb begin
      sq_held = '0;
      sq_in   = '0;
      for (int i = 1; i <= NUM_FU; i++) begin
         sq_held[i] = branch_mispredict && held_q[i] &&
                      in_squash_range(32'(tag_q[i]), 32'(branch_rob_tag), 32'(rob_tail_tag));
         sq_in[i]   = branch_mispredict &&
                      in_squash_range(32'(fu_result_tag[i]), 32'(branch_rob_tag), 32'(rob_tail_tag));
      end
   end

   // Squashed entries are dropped this cycle, so they must not win the bus.
   assign req = held_q & ~sq_held;

   rr_arbiter #(.N(NUM_FU), .IW(IW)) u_rr (
      .req   (req),
      .last  (last_q),
      .grant (grant)
   );

   // A granted slot empties this cycle, so it can be refilled in the same cycle.
   assign ready = ~held_q | grant;
   assign xfer  = fu_result_valid & ready;

   always_comb begin
      held_d      = held_q;
      tag_d       = tag_q;
      value_d     = value_q;
      last_d      = last_q;
      cdb_valid_d = 1'b0;
      cdb_tag_d   = '0;
      cdb_value_d = '0;
      for (int i = 1; i <= NUM_FU; i++) begin
         if (grant[i] || sq_held[i]) held_d[i] = 1'b0;
         // Squashed incoming results are consumed (ready stays honest) but not kept.
         if (xfer[i]) begin
            held_d[i]  = !sq_in[i];
            tag_d[i]   = fu_result_tag[i];
            value_d[i] = fu_result_value[i];
         end
         if (grant[i]) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = tag_q[i];
            cdb_value_d = value_q[i];
            last_d      = IW'(i);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         held_q      <= '0;
         tag_q       <= '0;
         value_q     <= '0;
         last_q      <= IW'(NUM_FU);
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_value_q <= '0;
         fu_done_q   <= '0;
      end else begin
         held_q      <= held_d;
         tag_q       <= tag_d;
         value_q     <= value_d;
         last_q      <= last_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_value_q <= cdb_value_d;
         fu_done_q   <= grant;
      end
   end

   assign fu_result_ready = ready;
   assign cdb_valid       = cdb_valid_q;
   assign cdb_rob_tag     = cdb_tag_q;
   assign cdb_value       = cdb_value_q;
   assign fu_done         = fu_done_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

   localparam int NUM_FU = 6;
   localparam int XLEN   = 32;
   localparam int TW     = 5;

   logic                       clock;
   logic                       reset;
   logic [NUM_FU:1]            fu_result_valid;
   logic [NUM_FU:1][TW-1:0]    fu_result_tag;
   logic [NUM_FU:1][XLEN-1:0]  fu_result_value;
   logic [NUM_FU:1]            fu_result_ready;
   logic                       branch_mispredict;
   logic [TW-1:0]              branch_rob_tag;
   logic [TW-1:0]              rob_tail_tag;
   logic                       cdb_valid;
   logic [TW-1:0]              cdb_rob_tag;
   logic [XLEN-1:0]            cdb_value;
   logic [NUM_FU:1]            fu_done;

   int n_chk  = 0;
   int n_pass = 0;

   cdb_arbiter #(.NUM_FU(NUM_FU), .XLEN(XLEN), .ROB_TAG_W(TW)) dut (
      .clock             (clock),
      .reset             (reset),
      .fu_result_valid   (fu_result_valid),
      .fu_result_tag     (fu_result_tag),
      .fu_result_value   (fu_result_value),
      .fu_result_ready   (fu_result_ready),
      .branch_mispredict (branch_mispredict),
      .branch_rob_tag    (branch_rob_tag),
      .rob_tail_tag      (rob_tail_tag),
      .cdb_valid         (cdb_valid),
      .cdb_rob_tag       (cdb_rob_tag),
      .cdb_value         (cdb_value),
      .fu_done           (fu_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      fu_result_valid   = '0;
      fu_result_tag     = '0;
      fu_result_value   = '0;
      branch_mispredict = 1'b0;
      branch_rob_tag    = '0;
      rob_tail_tag      = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      #1;
      n_chk++; if (cdb_valid !== 1'b0) $display("FAIL rst_valid: got %0h want 0", cdb_valid); else n_pass++;
      n_chk++; if (cdb_rob_tag !== 5'd0) $display("FAIL rst_tag: got %0h want 0", cdb_rob_tag); else n_pass++;
      n_chk++; if (cdb_value !== 32'd0) $display("FAIL rst_value: got %0h want 0", cdb_value); else n_pass++;
      n_chk++; if (fu_done !== 6'd0) $display("FAIL rst_done: got %0h want 0", fu_done); else n_pass++;
      n_chk++; if (fu_result_ready !== 6'h3F) $display("FAIL rst_ready: got %0h want 3f", fu_result_ready); else n_pass++;
      step();
      reset = 1'b1;
      step();
      n_chk++; if (cdb_valid !== 1'b0) $display("FAIL rst_post_valid: got %0h want 0", cdb_valid); else n_pass++;
      n_chk++; if (fu_result_ready !== 6'h3F) $display("FAIL rst_post_ready: got %0h want 3f", fu_result_ready); else n_pass++;
   endtask

   task automatic test_single();
      do_reset();
      fu_result_valid[2] = 1'b1;
      fu_result_tag[2]   = 5'd5;
      fu_result_value[2] = 32'hDEAD;
      #1;
      n_chk++; if (fu_result_ready[2] !== 1'b1) $display("FAIL single_ready: got %0h want 1", fu_result_ready[2]); else n_pass++;
      step();
      clear_inputs();
      n_chk++; if (cdb_valid !== 1'b0) $display("FAIL single_c2_valid: got %0h want 0", cdb_valid); else n_pass++;
      step();
      n_chk++; if (cdb_valid !== 1'b1) $display("FAIL single_valid: got %0h want 1", cdb_valid); else n_pass++;
      n_chk++; if (cdb_rob_tag !== 5'd5) $display("FAIL single_tag: got %0h want 5", cdb_rob_tag); else n_pass++;
      n_chk++; if (cdb_value !== 32'hDEAD) $display("FAIL single_value: got %0h want dead", cdb_value); else n_pass++;
      n_chk++; if (fu_done !== 6'b000010) $display("FAIL single_done: got %0h want 02", fu_done); else n_pass++;
      step();
      n_chk++; if (cdb_valid !== 1'b0) $display("FAIL single_idle_valid: got %0h want 0", cdb_valid); else n_pass++;
      n_chk++; if (cdb_rob_tag !== 5'd0) $display("FAIL single_idle_tag: got %0h want 0", cdb_rob_tag); else n_pass++;
      n_chk++; if (fu_done !== 6'd0) $display("FAIL single_idle_done: got %0h want 0", fu_done); else n_pass++;
   endtask

   task automatic test_contention();
      do_reset();
      fu_result_valid = 6'b010101;
      fu_result_tag[1] = 5'd11; fu_result_value[1] = 32'h101;
      fu_result_tag[3] = 5'd13; fu_result_value[3] = 32'h103;
      fu_result_tag[5] = 5'd15; fu_result_value[5] = 32'h105;
      step();
      clear_inputs();
      #1;
      n_chk++; if (fu_result_ready !== 6'b101011) $display("FAIL cont_ready: got %0h want 2b", fu_result_ready); else n_pass++;
      step();
      n_chk++; if (cdb_rob_tag !== 5'd11 || fu_done !== 6'b000001) $display("FAIL cont_first: got tag %0d done %0h want 11 01", cdb_rob_tag, fu_done); else n_pass++;
      fu_result_valid[1] = 1'b1;
      fu_result_tag[1]   = 5'd21;
      fu_result_value[1] = 32'h201;
      step();
      clear_inputs();
      n_chk++; if (cdb_rob_tag !== 5'd13 || fu_done !== 6'b000100) $display("FAIL cont_second: got tag %0d done %0h want 13 04", cdb_rob_tag, fu_done); else n_pass++;
      step();
      n_chk++; if (cdb_rob_tag !== 5'd15 || fu_done !== 6'b010000) $display("FAIL cont_third: got tag %0d done %0h want 15 10", cdb_rob_tag, fu_done); else n_pass++;
      step();
      n_chk++; if (cdb_rob_tag !== 5'd21 || cdb_value !== 32'h201 || fu_done !== 6'b000001) $display("FAIL cont_refu1: got tag %0d value %0h done %0h want 21 201 01", cdb_rob_tag, cdb_value, fu_done); else n_pass++;
   endtask

   task automatic test_back_to_back();
      do_reset();
      fu_result_valid[1] = 1'b1;
      fu_result_tag[1]   = 5'd7;
      fu_result_value[1] = 32'h1;
      step();
      fu_result_tag[1]   = 5'd8;
      fu_result_value[1] = 32'h2;
      #1;
      n_chk++; if (fu_result_ready[1] !== 1'b1) $display("FAIL b2b_ready: got %0h want 1", fu_result_ready[1]); else n_pass++;
      step();
      clear_inputs();
      n_chk++; if (cdb_valid !== 1'b1 || cdb_rob_tag !== 5'd7) $display("FAIL b2b_first: got valid %0h tag %0d want 1 7", cdb_valid, cdb_rob_tag); else n_pass++;
      step();
      n_chk++; if (cdb_valid !== 1'b1 || cdb_rob_tag !== 5'd8 || cdb_value !== 32'h2) $display("FAIL b2b_second: got valid %0h tag %0d value %0h want 1 8 2", cdb_valid, cdb_rob_tag, cdb_value); else n_pass++;
      step();
      n_chk++; if (cdb_valid !== 1'b0) $display("FAIL b2b_idle: got %0h want 0", cdb_valid); else n_pass++;
   endtask

   task automatic test_squash_nowrap();
      do_reset();
      fu_result_valid = 6'b000111;
      fu_result_tag[1] = 5'd2; fu_result_value[1] = 32'h20;
      fu_result_tag[2] = 5'd4; fu_result_value[2] = 32'h40;
      fu_result_tag[3] = 5'd8; fu_result_value[3] = 32'h80;
      step();
      clear_inputs();
      branch_mispredict = 1'b1;
      branch_rob_tag    = 5'd3;
      rob_tail_tag      = 5'd7;
      #1;
      n_chk++; if (fu_result_ready !== 6'b111001) $display("FAIL sqn_ready: got %0h want 39", fu_result_ready); else n_pass++;
      step();
      clear_inputs();
      n_chk++; if (cdb_rob_tag !== 5'd2 || cdb_value !== 32'h20 || fu_done !== 6'b000001) $display("FAIL sqn_tag2: got tag %0d value %0h done %0h want 2 20 01", cdb_rob_tag, cdb_value, fu_done); else n_pass++;
      step();
      n_chk++; if (cdb_rob_tag !== 5'd8 || fu_done !== 6'b000100) $display("FAIL sqn_tag8: got tag %0d done %0h want 8 04", cdb_rob_tag, fu_done); else n_pass++;
      step();
      n_chk++; if (cdb_valid !== 1'b0 || fu_done !== 6'd0) $display("FAIL sqn_idle: got valid %0h done %0h want 0 0", cdb_valid, fu_done); else n_pass++;
   endtask

   task automatic test_squash_wrap();
      do_reset();
      fu_result_valid = 6'b000111;
      fu_result_tag[1] = 5'd30; fu_result_value[1] = 32'h300;
      fu_result_tag[2] = 5'd1;  fu_result_value[2] = 32'h10;
      fu_result_tag[3] = 5'd10; fu_result_value[3] = 32'hA0;
      step();
      clear_inputs();
      branch_mispredict  = 1'b1;
      branch_rob_tag     = 5'd28;
      rob_tail_tag       = 5'd2;
      fu_result_valid[4] = 1'b1;
      fu_result_tag[4]   = 5'd31;
      fu_result_value[4] = 32'h31;
      #1;
      n_chk++; if (fu_result_ready[4] !== 1'b1) $display("FAIL sqw_in_ready: got %0h want 1", fu_result_ready[4]); else n_pass++;
      step();
      clear_inputs();
      n_chk++; if (cdb_rob_tag !== 5'd10 || cdb_value !== 32'hA0 || fu_done !== 6'b000100) $display("FAIL sqw_tag10: got tag %0d value %0h done %0h want 10 a0 04", cdb_rob_tag, cdb_value, fu_done); else n_pass++;
      step();
      n_chk++; if (cdb_valid !== 1'b0 || fu_done !== 6'd0) $display("FAIL sqw_idle1: got valid %0h done %0h want 0 0", cdb_valid, fu_done); else n_pass++;
      step();
      n_chk++; if (cdb_valid !== 1'b0 || cdb_rob_tag !== 5'd0) $display("FAIL sqw_idle2: got valid %0h tag %0d want 0 0", cdb_valid, cdb_rob_tag); else n_pass++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      fu_result_valid = 6'b000111;
      fu_result_tag[1] = 5'd3; fu_result_value[1] = 32'h3;
      fu_result_tag[2] = 5'd4; fu_result_value[2] = 32'h4;
      fu_result_tag[3] = 5'd5; fu_result_value[3] = 32'h5;
      step();
      clear_inputs();
      step();
      n_chk++; if (cdb_valid !== 1'b1 || cdb_rob_tag !== 5'd3) $display("FAIL midrst_pre: got valid %0h tag %0d want 1 3", cdb_valid, cdb_rob_tag); else n_pass++;
      reset = 1'b0;
      #1;
      n_chk++; if (cdb_valid !== 1'b0 || cdb_rob_tag !== 5'd0 || cdb_value !== 32'd0 || fu_done !== 6'd0) $display("FAIL midrst_async: got valid %0h tag %0d value %0h done %0h want all 0", cdb_valid, cdb_rob_tag, cdb_value, fu_done); else n_pass++;
      n_chk++; if (fu_result_ready !== 6'h3F) $display("FAIL midrst_ready: got %0h want 3f", fu_result_ready); else n_pass++;
      step();
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         n_chk++; if (cdb_valid !== 1'b0 || fu_done !== 6'd0) $display("FAIL midrst_idle%0d: got valid %0h done %0h want 0 0", c, cdb_valid, fu_done); else n_pass++;
      end
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      #2;
      test_reset();
      test_single();
      test_contention();
      test_back_to_back();
      test_squash_nowrap();
      test_squash_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
